// File: rtl/timer_bank.sv
// timer_bank: multi-channel CPU-programmable down-counting timer on a Z80 chip-select window.
// Each channel has COUNT/RELOAD/CTRL/STAT registers, one-shot or auto-reload operation,
// a tear-free multi-byte COUNT read snapshot and a shared prescaler tick.
module timer_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 24000,
    localparam int unsigned ADDR_W  = $clog2(CHANNELS) + 4
) (
    input  logic                clk_24,
    input  logic                reset,
    input  logic                cs,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                wr,
    input  logic                rd,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic                irq_n,
    output logic [CHANNELS-1:0] expired
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned PS_W  = $clog2(PRESCALE);

    logic [PS_W-1:0]   presc;
    logic              tick;
    logic              wr_q;
    logic              rd_q;
    logic              wr_p;
    logic              rd_p;
    logic [ADDR_W-1:0] ch_sel;
    logic [3:0]        reg_sel;

    logic [WIDTH-1:0]    count  [CHANNELS];
    logic [WIDTH-1:0]    reload [CHANNELS];
    logic [WIDTH-1:0]    snap   [CHANNELS];
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] auto_rl;
    logic [CHANNELS-1:0] irqen;
    logic [CHANNELS-1:0] exp_q;

    logic [CHANNELS-1:0] wr_cnt;
    logic [CHANNELS-1:0] wr_rel;
    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] wr_stat;
    logic [CHANNELS-1:0] rd_snap;
    logic [CHANNELS-1:0] expire;

    logic             sel_hit;
    logic [WIDTH-1:0] sel_count;
    logic [WIDTH-1:0] sel_snap;
    logic [WIDTH-1:0] sel_reload;
    logic [WIDTH-1:0] cnt_word;
    logic [2:0]       sel_ctrl;
    logic             sel_exp;

    assign ch_sel  = addr >> 4;
    assign reg_sel = addr[3:0];
    assign tick    = (presc == PS_W'(PRESCALE - 1));
    assign wr_p    = cs & wr & ~wr_q;
    assign rd_p    = cs & rd & ~rd_q;
    assign expired = exp_q;

    // Free-running prescaler and bus strobe edge registers
    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            presc <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
            wr_q  <= cs & wr;
            rd_q  <= cs & rd;
        end
    end

    // Decode one-cycle register access strobes per channel; out-of-range channels match nothing
    always_comb begin
        wr_cnt  = '0;
        wr_rel  = '0;
        wr_ctrl = '0;
        wr_stat = '0;
        rd_snap = '0;
        expire  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == ADDR_W'(c)) begin
                wr_cnt[c]  = wr_p && (reg_sel[3:2] == 2'd0) && (32'(reg_sel[1:0]) < BYTES);
                wr_rel[c]  = wr_p && (reg_sel[3:2] == 2'd1) && (32'(reg_sel[1:0]) < BYTES);
                wr_ctrl[c] = wr_p && (reg_sel == 4'h8);
                wr_stat[c] = wr_p && (reg_sel == 4'h9);
                rd_snap[c] = rd_p && (reg_sel == 4'h0);
            end
            // A COUNT write in the tick cycle suppresses expiry as well as the decrement
            expire[c] = tick && en[c] && !wr_cnt[c] && (count[c] == '0);
        end
    end

    // Channel state: count/reload/ctrl/status/snapshot with collision priorities
    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c]  <= '0;
                reload[c] <= '0;
                snap[c]   <= '0;
            end
            en      <= '0;
            auto_rl <= '0;
            irqen   <= '0;
            exp_q   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_cnt[c]) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (reg_sel[1:0] == 2'(b)) count[c][8*b +: 8] <= din;
                    end
                end else if (tick && en[c]) begin
                    if (count[c] != '0) count[c] <= count[c] - WIDTH'(1);
                    else if (auto_rl[c]) count[c] <= reload[c];
                end
                if (wr_rel[c]) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (reg_sel[1:0] == 2'(b)) reload[c][8*b +: 8] <= din;
                    end
                end
                if (wr_ctrl[c]) begin
                    en[c]      <= din[0];
                    auto_rl[c] <= din[1];
                    irqen[c]   <= din[2];
                end else if (expire[c] && !auto_rl[c]) begin
                    en[c] <= 1'b0;
                end
                if (expire[c]) exp_q[c] <= 1'b1;
                else if (wr_stat[c] && din[0]) exp_q[c] <= 1'b0;
                if (rd_snap[c]) snap[c] <= count[c];
            end
        end
    end

    // Interrupt line, one cycle behind the flags
    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) irq_n <= 1'b1;
        else       irq_n <= ~|(exp_q & irqen);
    end

    // Read mux: COUNT byte 0 is live, higher COUNT bytes come from the snapshot
    always_comb begin
        dout       = '0;
        sel_hit    = 1'b0;
        sel_count  = '0;
        sel_snap   = '0;
        sel_reload = '0;
        sel_ctrl   = '0;
        sel_exp    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == ADDR_W'(c)) begin
                sel_hit    = 1'b1;
                sel_count  = count[c];
                sel_snap   = snap[c];
                sel_reload = reload[c];
                sel_ctrl   = {irqen[c], auto_rl[c], en[c]};
                sel_exp    = exp_q[c];
            end
        end
        cnt_word = (reg_sel[1:0] == 2'd0) ? sel_count : sel_snap;
        if (sel_hit) begin
            case (reg_sel[3:2])
                2'd0: begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (reg_sel[1:0] == 2'(b)) dout = cnt_word[8*b +: 8];
                    end
                end
                2'd1: begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (reg_sel[1:0] == 2'(b)) dout = sel_reload[8*b +: 8];
                    end
                end
                2'd2: begin
                    if (reg_sel[1:0] == 2'd0)      dout = {5'b0, sel_ctrl};
                    else if (reg_sel[1:0] == 2'd1) dout = {7'b0, sel_exp};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus random bus traffic against a behavioural timer model.
module tb_timer_bank;

    localparam int unsigned CH = 2;
    localparam int unsigned PS = 4;
    localparam int unsigned AW = 5;

    logic          clk_24 = 1'b0;
    logic          reset;
    logic          cs;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          irq_n;
    logic [CH-1:0] expired;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // behavioural model state
    logic [15:0] m_count  [CH];
    logic [15:0] m_reload [CH];
    logic [15:0] m_snap   [CH];
    bit          m_en     [CH];
    bit          m_auto   [CH];
    bit          m_irqen  [CH];
    bit          m_exp    [CH];
    int          m_presc;
    bit          m_wr_prev;
    bit          m_rd_prev;
    bit          m_irq_n;

    int reg_tab [8] = '{0, 1, 4, 5, 8, 9, 9, 12};

    timer_bank #(.CHANNELS(CH), .WIDTH(16), .PRESCALE(PS)) dut (
        .clk_24 (clk_24),
        .reset  (reset),
        .cs     (cs),
        .addr   (addr),
        .wr     (wr),
        .rd     (rd),
        .din    (din),
        .dout   (dout),
        .irq_n  (irq_n),
        .expired(expired)
    );

    always #5 clk_24 = ~clk_24;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    function automatic logic [7:0] m_dout(input logic [AW-1:0] a);
        int c;
        int r;
        c = int'(a >> 4);
        r = int'(a[3:0]);
        if (c >= CH) return 8'h00;
        case (r)
            0:       return m_count[c][7:0];
            1:       return m_snap[c][15:8];
            4:       return m_reload[c][7:0];
            5:       return m_reload[c][15:8];
            8:       return {5'b0, m_irqen[c], m_auto[c], m_en[c]};
            9:       return {7'b0, m_exp[c]};
            default: return 8'h00;
        endcase
    endfunction

    // Model: applies the register rules once per clock from the values seen before the edge
    initial forever begin
        bit          wl, rl, wp, rp, tk, hit, xp;
        int          ac, ar;
        logic [15:0] oc;
        @(posedge clk_24 or posedge reset);
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_count[c] = '0; m_reload[c] = '0; m_snap[c] = '0;
                m_en[c] = 0; m_auto[c] = 0; m_irqen[c] = 0; m_exp[c] = 0;
            end
            m_presc = 0; m_wr_prev = 0; m_rd_prev = 0; m_irq_n = 1;
        end else begin
            wl = cs & wr;
            rl = cs & rd;
            wp = wl && !m_wr_prev;
            rp = rl && !m_rd_prev;
            m_wr_prev = wl;
            m_rd_prev = rl;
            tk = (m_presc == PS - 1);
            m_presc = tk ? 0 : m_presc + 1;
            m_irq_n = !((m_exp[0] && m_irqen[0]) || (m_exp[1] && m_irqen[1]));
            ac = int'(addr >> 4);
            ar = int'(addr[3:0]);
            for (int c = 0; c < CH; c++) begin
                hit = wp && (ac == c);
                oc  = m_count[c];
                xp  = 0;
                if (hit && ar == 0) m_count[c][7:0] = din;
                else if (hit && ar == 1) m_count[c][15:8] = din;
                else if (tk && m_en[c]) begin
                    if (oc != 0) m_count[c] = oc - 16'd1;
                    else begin
                        xp = 1;
                        if (m_auto[c]) m_count[c] = m_reload[c];
                    end
                end
                if (rp && ac == c && ar == 0) m_snap[c] = oc;
                if (xp && !m_auto[c]) m_en[c] = 0;
                if (hit && ar == 8) begin
                    m_en[c] = din[0]; m_auto[c] = din[1]; m_irqen[c] = din[2];
                end
                if (hit && ar == 4) m_reload[c][7:0] = din;
                if (hit && ar == 5) m_reload[c][15:8] = din;
                if (xp) m_exp[c] = 1;
                else if (hit && ar == 9 && din[0]) m_exp[c] = 0;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge
    initial forever begin
        @(negedge clk_24);
        if (chk_on && !reset) begin
            check("dout", 32'(dout), 32'(m_dout(addr)));
            check("irq_n", 32'(irq_n), 32'(m_irq_n));
            check("expired", 32'(expired), 32'({m_exp[1], m_exp[0]}));
        end
    end

    // Bus tasks: called and returning at 1 ns after a rising edge
    task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d, input int hold);
        addr = a; din = d; cs = 1; wr = 1;
        repeat (hold) begin @(posedge clk_24); #1; end
        cs = 0; wr = 0;
        @(posedge clk_24); #1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [7:0] d);
        addr = a; cs = 1; rd = 1;
        #2 d = dout;
        @(posedge clk_24); #1;
        cs = 0; rd = 0;
        @(posedge clk_24); #1;
    endtask

    task automatic wait_phase(input int ph, input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (m_presc == ph) begin ok = 1; break; end
            @(posedge clk_24); #1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         n;
        bit         ok;
        int         seq_exp [6] = '{1, 0, 2, 1, 0, 2};

        reset = 1; cs = 0; wr = 0; rd = 0; addr = '0; din = '0;
        repeat (3) @(posedge clk_24);
        #1 reset = 0;
        chk_on = 1;

        // 1. reset state: every register reads zero while ticks run
        check("rst_irq_n", 32'(irq_n), 32'd1);
        check("rst_expired", 32'(expired), 32'd0);
        for (int a = 0; a < 32; a++) begin
            bus_read(AW'(a), d);
            check("rst_read", 32'(d), 32'd0);
        end

        // 2. one-shot with interrupt on ch0
        bus_write(5'h00, 8'h03, 1);
        bus_write(5'h08, 8'h05, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (expired[0]) break;
            n++;
            @(posedge clk_24); #1;
        end
        check("os_exp_seen", 32'(expired[0]), 32'd1);
        check("os_latency", 32'(n >= 11 && n <= 16), 32'd1);
        check("os_irq_lag", 32'(irq_n), 32'd1);
        @(posedge clk_24); #1;
        check("os_irq_low", 32'(irq_n), 32'd0);
        bus_read(5'h08, d);
        check("os_ctrl", 32'(d), 32'h04);
        bus_read(5'h00, d);
        check("os_count", 32'(d), 32'h00);
        bus_write(5'h09, 8'h01, 1);
        check("os_w1c_irq", 32'(irq_n), 32'd1);
        check("os_w1c_exp", 32'(expired[0]), 32'd0);

        // 3. auto-reload on ch1, no interrupt
        bus_write(5'h14, 8'h02, 1);
        bus_write(5'h15, 8'h00, 1);
        bus_write(5'h10, 8'h02, 1);
        bus_write(5'h11, 8'h00, 1);
        bus_write(5'h18, 8'h03, 1);
        for (int i = 0; i < 6; i++) begin
            wait_phase(0, "ar_wait");
            bus_read(5'h10, d);
            check("ar_seq", 32'(d), 32'(seq_exp[i]));
        end
        check("ar_exp", 32'(expired[1]), 32'd1);
        check("ar_irq", 32'(irq_n), 32'd1);
        bus_write(5'h18, 8'h00, 1);
        bus_write(5'h19, 8'h01, 1);

        // 4. tear-free read across the 0x0100 -> 0x00FF borrow
        bus_write(5'h00, 8'h01, 1);
        bus_write(5'h01, 8'h01, 1);
        bus_write(5'h08, 8'h01, 1);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (m_count[0] == 16'h0100 && m_presc == PS - 1) begin ok = 1; break; end
            @(posedge clk_24); #1;
        end
        check("tf_wait", 32'(ok), 32'd1);
        bus_read(5'h00, d);
        check("tf_byte0", 32'(d), 32'h00);
        bus_read(5'h01, d);
        check("tf_byte1", 32'(d), 32'h01);
        bus_write(5'h08, 8'h00, 1);

        // 5a. W1C in the same cycle as expiry: set wins
        bus_write(5'h00, 8'h00, 1);
        bus_write(5'h01, 8'h00, 1);
        wait_phase(0, "c1_wait0");
        bus_write(5'h08, 8'h01, 1);
        wait_phase(PS - 1, "c1_wait3");
        bus_write(5'h09, 8'h01, 1);
        check("col_w1c_vs_set", 32'(expired[0]), 32'd1);

        // 5b. COUNT write in the tick cycle: written value, no decrement
        bus_write(5'h11, 8'h00, 1);
        bus_write(5'h10, 8'h10, 1);
        bus_write(5'h18, 8'h01, 1);
        wait_phase(PS - 1, "c2_wait3");
        bus_write(5'h10, 8'h33, 1);
        bus_read(5'h10, d);
        check("col_cnt_vs_tick", 32'(d), 32'h33);

        // 5c. write held for 10 cycles acts once, so the channel keeps counting
        bus_write(5'h10, 8'h20, 10);
        bus_read(5'h10, d);
        check("held_wr_once", 32'(d == 8'h1D || d == 8'h1E), 32'd1);

        // 6. asynchronous reset between edges while counting with irq asserted
        bus_write(5'h08, 8'h04, 1);
        check("pre_rst_irq", 32'(irq_n), 32'd0);
        check("pre_rst_exp", 32'(expired[0]), 32'd1);
        addr = 5'h10;
        #3 reset = 1;
        #1;
        check("arst_irq_n", 32'(irq_n), 32'd1);
        check("arst_expired", 32'(expired), 32'd0);
        check("arst_dout", 32'(dout), 32'd0);
        repeat (2) @(posedge clk_24);
        #1 reset = 0;
        bus_read(5'h10, d);
        check("post_rst_cnt", 32'(d), 32'd0);
        bus_read(5'h18, d);
        check("post_rst_ctrl", 32'(d), 32'd0);

        // random traffic, continuously compared against the model
        for (int i = 0; i < 300; i++) begin
            int         op;
            int         c;
            int         r;
            logic [7:0] dv;
            op = int'($urandom_range(0, 9));
            c  = int'($urandom_range(0, 1));
            r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : reg_tab[$urandom_range(0, 7)];
            if (r == 0 || r == 4)      dv = 8'($urandom_range(0, 6));
            else if (r == 1 || r == 5) dv = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
            else                       dv = 8'($urandom);
            if (op < 5) bus_write(AW'(c * 16 + r), dv, int'($urandom_range(1, 3)));
            else if (op < 8) bus_read(AW'(c * 16 + r), dv);
            else if (op == 8) repeat ($urandom_range(1, 6)) begin @(posedge clk_24); #1; end
            else begin
                addr = AW'(c * 16 + r); din = dv; wr = 1;
                @(posedge clk_24); #1;
                wr = 0;
            end
        end

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
